// File: rtl/ceil_share_arb.sv
// ceil_share_arb: round-robin sharing of one saturating-round (ceil) unit among NREQ requesters.
// Latency: rsp_valid rises LAT+1 edges after the grant edge; one transaction in flight (LAT+3 cycles min).
// Backpressure: response held stable until rsp_ready; no new grant until the arbiter is back in IDLE.
// Ports: clock, rst_n (sync, active-low); req_valid/req_ready/req_data (flattened, DSIZE per requester);
//        rsp_valid/rsp_ready/rsp_data/rsp_id result channel; ceil_indata/ceil_outdata to the unit; busy.
module ceil_share_arb #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int DSIZE = 16,
  parameter int OSIZE = 8,
  parameter int LAT   = 1
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OSIZE-1:0]        rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic [DSIZE-1:0]        ceil_indata,
  input  logic [OSIZE-1:0]        ceil_outdata,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, CALC, WAIT, RESP} state_t;

  // Pointer starts at the last requester so requester 0 is searched first.
  localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   tag_q;
  logic [DSIZE-1:0] indata_q;
  logic [OSIZE-1:0] rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_valid_q;
  logic             busy_q;

  logic             win_vld_d;
  logic [IDW-1:0]   win_idx_d;
  logic [DSIZE-1:0] win_data_d;

  // Round-robin pick: lowest valid index above the pointer wins; if none,
  // wrap around to the lowest valid index at or below it. Descending loop so
  // the last hit in each half is the lowest index.
  logic             hi_vld, lo_vld;
  logic [IDW-1:0]   hi_idx, lo_idx;
  logic [DSIZE-1:0] hi_data, lo_data;

  always_comb begin
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    hi_data = '0;
    lo_data = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) > rr_ptr_q) begin
          hi_vld  = 1'b1;
          hi_idx  = IDW'(i);
          hi_data = req_data[i*DSIZE +: DSIZE];
        end else begin
          lo_vld  = 1'b1;
          lo_idx  = IDW'(i);
          lo_data = req_data[i*DSIZE +: DSIZE];
        end
      end
    end
    win_vld_d  = hi_vld | lo_vld;
    win_idx_d  = hi_vld ? hi_idx  : lo_idx;
    win_data_d = hi_vld ? hi_data : lo_data;
  end

  // Grants only leave IDLE; the response handshake cycle is RESP, so it can
  // never coincide with a grant.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == IDLE) && win_vld_d && (win_idx_d == IDW'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PTR_RST;
      tag_q       <= '0;
      indata_q    <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            indata_q <= win_data_d;
            tag_q    <= win_idx_d;
            rr_ptr_q <= win_idx_d;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          // Combinational unit: result is already valid on ceil_outdata.
          if (LAT == 0) begin
            rsp_data_q  <= ceil_outdata;
            rsp_id_q    <= tag_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // Registered unit captured indata at the end of CALC.
          rsp_data_q  <= ceil_outdata;
          rsp_id_q    <= tag_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ceil_indata = indata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign busy        = busy_q;

endmodule
